uart_rx_8n1: RTL and testbench

- Asynchronous serial receiver for 8N1 framing: one start bit, DATA_BITS data bits LSB first, one stop bit, no parity.
- Recovers bytes from a single-wire line and presents each one as a parallel word with a one-cycle valid strobe.
- Companion receive end to the team's serial transmit path; sits between the board RX pin and byte-level consumer logic.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx_8n1.sv | 131 +++++++++++++
 tb/tb_uart_rx_8n1.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default bit-period constant
// Purpose: state encoding and timing default shared by the serial receive and
//          transmit paths.
// Contents: uart_state_t (3-bit FSM encoding), UART_CLK_DIV (50 MHz / 115200).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam int unsigned UART_CLK_DIV = 434;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
// Purpose: bring an asynchronous level into the clk domain with 2 cycles of latency.
// Ports:
//   clk   in   system clock, rising edge
//   rst_n in   asynchronous active-low reset; both flops load RESET_VAL
//   d     in   asynchronous input
//   q     out  synchronized copy of d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 asynchronous serial receiver
// Purpose: recover start/data/stop frames (LSB first, no parity) from a single
//          idle-high line and present each word with a one-cycle strobe.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   data_out   out  last correctly framed word, held until the next one
//   data_valid out  one-cycle pulse when data_out updates
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   busy       out  high in every state except IDLE
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = UART_CLK_DIV,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;

  // Reset value 1 keeps the line looking idle so reset release never fakes a start edge.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        // Half a bit in: confirm the start bit is still low, otherwise treat it as a glitch.
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
              idx   <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == IDX_LAST) begin
              state <= ST_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Returning to IDLE right after the stop sample leaves half a bit to catch a
        // back-to-back start edge.
        ST_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A held-low line must go high before another frame can start.
        ST_BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - self-checking bench for uart_rx_8n1
module tb_uart_rx_8n1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx16 = 1'b1;
  logic [7:0] do8, do16;
  logic       dv8, dv16, fe8, fe16, bz8, bz16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_rx_8n1 #(.CLK_DIV(8), .DATA_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .rx(rx8),
    .data_out(do8), .data_valid(dv8), .frame_err(fe8), .busy(bz8)
  );

  uart_rx_8n1 #(.CLK_DIV(16), .DATA_BITS(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .rx(rx16),
    .data_out(do16), .data_valid(dv16), .frame_err(fe16), .busy(bz16)
  );

  // Observation: cumulative event counts and received words, sampled on the falling edge.
  int         cyc = 0;
  logic [7:0] got8[$];
  logic [7:0] got16[$];
  int         t8[$];
  int         nv8 = 0, nfe8 = 0, nbz8 = 0, nv16 = 0, nfe16 = 0, nboth = 0;
  logic       pb8 = 1'b0;
  logic [1:0] vb8 = 2'b00;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dv8) begin
      got8.push_back(do8);
      t8.push_back(cyc);
      nv8++;
      vb8 = {pb8, bz8};
    end
    if (fe8) nfe8++;
    if (bz8) nbz8++;
    if ((dv8 && fe8) || (dv16 && fe16)) nboth++;
    pb8 = bz8;
    if (dv16) begin
      got16.push_back(do16);
      nv16++;
    end
    if (fe16) nfe16++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx16 = v;
    else rx8 = v;
  endtask

  // One frame: start bit, 8 data bits LSB first, stop level; each bit lasts bl cycles.
  task automatic send(input bit sel, input logic [7:0] b, input logic stop, input int bl);
    set_rx(sel, 1'b0);
    repeat (bl) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      repeat (bl) @(negedge clk);
    end
    set_rx(sel, stop);
    repeat (bl) @(negedge clk);
  endtask

  int         v0, fe0, bz0, base, nexp_fe;
  logic [7:0] b;
  logic [7:0] exp_q[$];

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", do8, 8'h00);
    check("rst_data_valid", dv8, 1'b0);
    check("rst_frame_err", fe8, 1'b0);
    check("rst_busy", bz8, 1'b0);
    check("rst_busy16", bz16, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Normal frame 0xA5
    v0 = nv8; fe0 = nfe8;
    send(0, 8'hA5, 1'b1, 8);
    repeat (10) @(negedge clk);
    check("a5_pulses", nv8 - v0, 1);
    check("a5_data", do8, 8'hA5);
    check("a5_no_ferr", nfe8 - fe0, 0);
    check("a5_busy_edge", vb8, 2'b10);

    // Glitch: two low cycles only
    v0 = nv8; fe0 = nfe8; bz0 = nbz8;
    rx8 = 1'b0;
    repeat (2) @(negedge clk);
    rx8 = 1'b1;
    repeat (5) @(negedge clk);
    check("glitch_busy_low", bz8, 1'b0);
    check("glitch_busy_seen", (nbz8 - bz0) > 0, 1'b1);
    repeat (10) @(negedge clk);
    check("glitch_no_valid", nv8 - v0, 0);
    check("glitch_no_ferr", nfe8 - fe0, 0);
    check("glitch_data", do8, 8'hA5);

    // Framing error after a good 0x3C
    send(0, 8'h3C, 1'b1, 8);
    repeat (4) @(negedge clk);
    v0 = nv8; fe0 = nfe8;
    send(0, 8'h55, 1'b0, 8);
    repeat (40) @(negedge clk);
    check("ferr_pulses", nfe8 - fe0, 1);
    check("ferr_no_valid", nv8 - v0, 0);
    check("ferr_data_held", do8, 8'h3C);
    check("ferr_busy_held", bz8, 1'b1);
    rx8 = 1'b1;
    repeat (5) @(negedge clk);
    check("ferr_busy_release", bz8, 1'b0);

    // Back-to-back 0x00 then 0xFF
    v0 = nv8; base = got8.size();
    send(0, 8'h00, 1'b1, 8);
    send(0, 8'hFF, 1'b1, 8);
    repeat (10) @(negedge clk);
    check("b2b_pulses", nv8 - v0, 2);
    if (nv8 - v0 == 2) begin
      check("b2b_first", got8[base], 8'h00);
      check("b2b_second", got8[base+1], 8'hFF);
      check("b2b_spacing", t8[base+1] - t8[base], 80);
    end

    // Reset during data bit 4 of 0x81
    v0 = nv8; fe0 = nfe8;
    rx8 = 1'b0;
    repeat (8) @(negedge clk);
    b = 8'h81;
    for (int i = 0; i < 4; i++) begin
      rx8 = b[i];
      repeat (8) @(negedge clk);
    end
    rx8 = b[4];
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    rx8 = 1'b1;
    #1;
    check("arst_data_out", do8, 8'h00);
    check("arst_busy", bz8, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("arst_no_pulse", (nv8 - v0) + (nfe8 - fe0), 0);
    send(0, 8'h42, 1'b1, 8);
    repeat (10) @(negedge clk);
    check("after_rst_pulses", nv8 - v0, 1);
    check("after_rst_data", do8, 8'h42);
    check("after_rst_no_ferr", nfe8 - fe0, 0);

    // Baud skew: 17-cycle bits into a 16-cycle receiver
    v0 = nv16; fe0 = nfe16;
    send(1, 8'hC3, 1'b1, 17);
    repeat (10) @(negedge clk);
    check("skew_pulses", nv16 - v0, 1);
    check("skew_data", do16, 8'hC3);
    check("skew_no_ferr", nfe16 - fe0, 0);

    // Random frames: the model is the list of well-framed bytes plus a count of bad stops
    v0 = nv8; fe0 = nfe8; base = got8.size(); nexp_fe = 0;
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        send(0, b, 1'b0, 8);
        repeat ($urandom_range(0, 12)) @(negedge clk);
        rx8 = 1'b1;
        repeat (4) @(negedge clk);
        nexp_fe++;
      end else begin
        send(0, b, 1'b1, 8);
        exp_q.push_back(b);
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    repeat (20) @(negedge clk);
    check("rand_count", nv8 - v0, exp_q.size());
    check("rand_ferr", nfe8 - fe0, nexp_fe);
    if (nv8 - v0 == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) check("rand_byte", got8[base+i], exp_q[i]);
    check("never_both", nboth, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
